// File: rtl/alu_driver_if.sv
// alu_driver_if -- request/response bus between a client and alu_driver.
//   Request channel  : req_valid/req_ready handshake carrying req_a, req_b,
//                      req_op, req_cin and req_chain (use the stored carry).
//   Response channel : rsp_valid/rsp_ready handshake carrying rsp_result
//                      and rsp_cout.
//   master modport : the client side (offers requests, consumes responses).
//   slave modport  : the alu_driver side.
interface alu_driver_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic             req_cin;
  logic             req_chain;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_op, req_cin, req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_cin, req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_cout
  );
endinterface

// File: rtl/alu_driver.sv
// alu_driver -- sequences one request at a time through an external ALU that
// has a registered result and a combinational carry-out.
//   clk, rst   : single clock; asynchronous active-high reset.
//   bus        : request/response channels (alu_driver_if.slave).
//   alu_a/b    : operands held stable toward the ALU for the whole transaction.
//   alu_op     : opcode passed through unmodified.
//   alu_cin    : req_cin, or the stored carry when req_chain is set.
//   alu_enbl   : one-cycle enable of the ALU output register (EXEC only).
//   alu_result : registered ALU result, sampled in WAIT.
//   alu_cout   : combinational ALU carry-out, sampled in EXEC.
//   op_count   : completed transactions, wraps at 16 bits.
// Flow: IDLE -> EXEC -> WAIT -> RESP -> IDLE; one transaction per 4 cycles
// at best.
module alu_driver #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_driver_if.slave      bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_cin,
  output logic             alu_enbl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic             accept;
  logic             done;
  logic             carry_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_cout_q;
  logic [15:0]      op_count_q;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake decode.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    alu_enbl      = 1'b0;
    accept        = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_enbl = 1'b1;
        state_d  = WAIT;
      end
      WAIT: state_d = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        // A consumer already ready on the first RESP cycle completes here.
        if (bus.rsp_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Datapath. Registers only load in their own state, so operands stay put
  // toward the ALU and the response holds through backpressure and after
  // returning to IDLE.
  // NOTE: all datapath flops are plain registers (no memory arrays), so each
  // gets an explicit reset value and reset aborts any transaction cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      alu_cin      <= 1'b0;
      carry_q      <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      if (accept) begin
        alu_a   <= bus.req_a;
        alu_b   <= bus.req_b;
        alu_op  <= bus.req_op;
        alu_cin <= bus.req_chain ? carry_q : bus.req_cin;
      end
      // Carry-out is combinational, so it is valid while operands are applied;
      // every transaction overwrites the stored carry, chained or not.
      if (state_q == EXEC) begin
        carry_q    <= alu_cout;
        rsp_cout_q <= alu_cout;
      end
      // The ALU result register loaded on the EXEC edge; take it one cycle on.
      if (state_q == WAIT) rsp_result_q <= alu_result;
      if (done)            op_count_q   <= op_count_q + 16'd1;
    end
  end

  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver -- directed vectors for alu_driver with a scoreboard queue.
// Each issued request pushes its expected response; a monitor pops and
// compares on every response handshake. A registered adder models the ALU.
module tb_alu_driver;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [2:0]    alu_op;
  logic          alu_cin, alu_enbl, alu_cout;
  logic [15:0]   op_count;
  logic [W:0]    sum;

  int total = 0;
  int bad   = 0;
  int enbl_cnt  = 0;
  int valid_cnt = 0;
  logic [15:0] model_cnt = '0;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic [15:0]  cnt;
  } exp_t;
  exp_t sb[$];

  alu_driver_if #(.WIDTH(W)) bus ();

  alu_driver #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_enbl   (alu_enbl),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  // ALU model: {cout, r} = a + b + cin, result registered under enbl.
  assign sum      = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
  assign alu_cout = sum[W];
  initial alu_result = '0;
  always_ff @(posedge clk) if (alu_enbl) alu_result <= sum[W-1:0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (alu_enbl)      enbl_cnt++;
    if (bus.rsp_valid) valid_cnt++;
  end

  // Monitor: compare every completed response against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_result", 64'(bus.rsp_result), 64'(e.r));
        check("rsp_cout",   64'(bus.rsp_cout),   64'(e.c));
        check("op_count_pre", 64'(op_count),     64'(e.cnt));
      end
    end
  end

  // Offer one request from a negedge, hold it over the accepting edge, and
  // return at the negedge of the EXEC cycle.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic cin, input logic chain, input bit push,
                      input logic [W-1:0] er, input logic ec);
    if (push) begin
      exp_t e;
      e.r = er; e.c = ec; e.cnt = model_cnt;
      sb.push_back(e);
      model_cnt++;
    end
    @(negedge clk);
    bus.req_a = a; bus.req_b = b; bus.req_op = op;
    bus.req_cin = cin; bus.req_chain = chain; bus.req_valid = 1'b1;
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("alu_a_latched",  64'(alu_a),    64'(a));
    check("alu_op_latched", 64'(alu_op),   64'(op));
    check("alu_enbl_exec",  64'(alu_enbl), 64'd1);
  endtask

  // From the EXEC negedge, wait (bounded) for rsp_valid; the first RESP cycle
  // is the third negedge after the accepting edge.
  task automatic wait_rsp();
    int k = 1;
    while (!bus.rsp_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("latency", 64'(k), 64'd3);
  endtask

  task automatic do_reset_abort(input string name);
    #2 rst = 1'b1;
    sb.delete();
    model_cnt = '0;
    #1;
    check({name, "_req_ready"}, 64'(bus.req_ready),  64'd1);
    check({name, "_alu_enbl"},  64'(alu_enbl),       64'd0);
    check({name, "_alu_a"},     64'(alu_a),          64'd0);
    check({name, "_alu_cin"},   64'(alu_cin),        64'd0);
    check({name, "_rsp_res"},   64'(bus.rsp_result), 64'd0);
    check({name, "_rsp_cout"},  64'(bus.rsp_cout),   64'd0);
    check({name, "_op_count"},  64'(op_count),       64'd0);
    enbl_cnt = 0;
    valid_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check({name, "_no_enbl"},  64'(enbl_cnt),  64'd0);
    check({name, "_no_valid"}, 64'(valid_cnt), 64'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.req_cin = 1'b0; bus.req_chain = 1'b0; bus.rsp_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_alu_enbl",  64'(alu_enbl),      64'd0);
    check("rst_alu_b",     64'(alu_b),         64'd0);
    check("rst_op_count",  64'(op_count),      64'd0);
    rst = 1'b0;

    // Single transaction.
    enbl_cnt = 0;
    send(32'h5, 32'h3, 3'd2, 1'b0, 1'b0, 1'b1, 32'h8, 1'b0);
    wait_rsp();
    @(negedge clk);
    check("single_op_count", 64'(op_count), 64'd1);
    check("single_enbl",     64'(enbl_cnt), 64'd1);

    // Chained carry.
    enbl_cnt = 0;
    send(32'hFFFF_FFFF, 32'h1, 3'd0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    wait_rsp();
    @(negedge clk);
    check("chain1_enbl", 64'(enbl_cnt), 64'd1);
    enbl_cnt = 0;
    send(32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1, 32'h1, 1'b0);
    check("chain_alu_cin", 64'(alu_cin), 64'd1);
    wait_rsp();
    @(negedge clk);
    check("chain2_enbl", 64'(enbl_cnt), 64'd1);

    // Non-chained request overwrites the stored carry (cout=0), and chain
    // ignores req_cin.
    send(32'h1, 32'h2, 3'd5, 1'b1, 1'b0, 1'b1, 32'h4, 1'b0);
    wait_rsp();
    send(32'h7, 32'h0, 3'd5, 1'b1, 1'b1, 1'b1, 32'h7, 1'b0);
    wait_rsp();
    @(negedge clk);
    check("count_after_5", 64'(op_count), 64'd5);

    // Backpressure for 5 RESP cycles with a dropped request pulse.
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    enbl_cnt = 0;
    send(32'h10, 32'h20, 3'd1, 1'b0, 1'b0, 1'b1, 32'h30, 1'b0);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid",  64'(bus.rsp_valid),  64'd1);
      check("bp_rsp_result", 64'(bus.rsp_result), 64'h30);
      check("bp_req_ready",  64'(bus.req_ready),  64'd0);
      if (i == 1) begin
        bus.req_a = 32'h99; bus.req_b = 32'h1; bus.req_valid = 1'b1;
      end
      if (i == 2) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    check("bp_alu_a_held", 64'(alu_a), 64'h10);
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("bp_enbl_once", 64'(enbl_cnt),       64'd1);
    check("bp_sb_empty",  64'(sb.size()),      64'd0);
    check("bp_idle",      64'(bus.req_ready),  64'd1);
    check("bp_retained",  64'(bus.rsp_result), 64'h30);
    check("bp_count",     64'(op_count),       64'd6);

    // Reset during EXEC.
    send(32'd100, 32'd200, 3'd3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_reset_abort("rst_exec");
    send(32'h2, 32'h2, 3'd0, 1'b0, 1'b0, 1'b1, 32'h4, 1'b0);
    wait_rsp();

    // Reset during WAIT after the aborted request captured a carry of 1;
    // the following chained request must see the cleared carry.
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    do_reset_abort("rst_wait");
    send(32'h5, 32'h0, 3'd0, 1'b1, 1'b1, 1'b1, 32'h5, 1'b0);
    wait_rsp();
    @(negedge clk);
    check("post_rst_count", 64'(op_count), 64'd1);

    // Wrap: preload the counter to 0xFFFF, then complete one more.
    force dut.op_count_q = 16'hFFFF;
    #1 release dut.op_count_q;
    model_cnt = 16'hFFFF;
    check("preload", 64'(op_count), 64'hFFFF);
    send(32'h3, 32'h4, 3'd0, 1'b0, 1'b0, 1'b1, 32'h7, 1'b0);
    wait_rsp();
    @(negedge clk);
    check("wrap_count", 64'(op_count), 64'h0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
